instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the RV32IM core. Holds the program counter, drives the word address of the combinational instruction memory, and captures the returned instruction in an IF/ID output register with a valid/ready handshake toward decode. Accepts branch/jump redirects from execute, flushes the output register on a redirect, and locks into a fault state on a misaligned redirect target.

## Interface

Parameters:
- ADDR_WIDTH, default 5: instruction memory word-address width. The mapped region is bytes 0 to (4·2^ADDR_WIDTH − 1).
- RESET_PC, default 32'h00000000: PC loaded on reset. Must be word aligned.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  ADDR_WIDTH  word address to instruction memory, equal to pc[ADDR_WIDTH+1:2]. Combinational from pc.
- imem_data  input  32  instruction word from memory, valid in the same cycle as imem_addr.
- redirect_valid  input  1  execute requests a PC change this cycle.
- redirect_pc  input  32  byte address of the redirect target.
- if_valid  output  1  if_instr, if_pc and if_pc_plus4 hold a valid instruction.
- if_ready  input  1  decode accepts the output this cycle.
- if_instr  output  32  fetched instruction.
- if_pc  output  32  byte PC of if_instr.
- if_pc_plus4  output  32  if_pc + 4, modulo 2^32.
- fetch_fault  output  1  sticky flag: a misaligned redirect was received.
- fetch_count  output  32  count of completed handshakes, wrapping modulo 2^32.

## Operation

- The state machine has two states: RUN and FAULT. Reset enters RUN.
- Load condition: load = (state == RUN) && (!if_valid || if_ready).
- Fetched word:
  - If pc < 4·2^ADDR_WIDTH, the fetched word is imem_data.
  - Otherwise it is the NOP 32'h00000013. Addresses outside the mapped region never alias back into memory.
- RUN, redirect_valid = 1 with redirect_pc[1:0] == 0 (highest priority):
  - pc <= redirect_pc.
  - if_valid <= 0, flushing any held instruction.
  - The state stays RUN.
- RUN, redirect_valid = 1 with redirect_pc[1:0] != 0:
  - The state goes to FAULT.
  - fetch_fault <= 1 and if_valid <= 0.
  - pc is unchanged.
- RUN, no redirect, load = 1:
  - if_instr <= fetched word, if_pc <= pc, if_pc_plus4 <= pc + 4, if_valid <= 1.
  - pc <= pc + 4. The PC wraps modulo 2^32.
- RUN, no redirect, load = 0 (stall: if_valid && !if_ready): all outputs and pc hold.
- FAULT:
  - Redirects are ignored and no fetch occurs.
  - if_valid stays 0 and fetch_fault stays 1.
  - Only rst_n leaves this state.
- fetch_count increments on every edge where if_valid && if_ready is true, in any state. A redirect in the same cycle does not suppress the increment, because downstream has already taken the word.
- Reset mid-operation immediately restores every reset value and discards any held instruction.

## Timing

- Reset values:
  - pc = RESET_PC, state = RUN, if_valid = 0, if_instr = 32'h00000013.
  - if_pc = RESET_PC, if_pc_plus4 = RESET_PC + 4.
  - fetch_fault = 0, fetch_count = 0.
- Latency:
  - The first rising edge after rst_n deasserts loads the instruction at RESET_PC; if_valid is high after that edge.
  - pc to if_instr is 1 cycle.
- Throughput: one instruction per cycle while if_ready = 1 and there is no redirect.
- Redirect:
  - Redirect sampled at edge N: if_valid = 0 during cycle N+1.
  - The target instruction is presented with if_valid = 1 after edge N+1.
  - The redirect bubble is 1 cycle.
- Stall: outputs stay stable for every cycle that if_valid && !if_ready holds. The if_ready → load path is combinational, with no extra cycle.
- A redirect during a stall flushes it: if_valid falls at the next edge even though if_ready = 0.
- Back-to-back redirects: the last one wins, and each one produces a bubble.
- imem_addr changes only after pc updates. There is no combinational path from redirect_pc to imem_addr.

## Test plan

- Reset then stream: memory words 0..2 = 01200093, fc800113, 021101b3; hold if_ready=1. Required response: if_instr 01200093, fc800113, 021101b3 on successive cycles; if_pc = 0, 4, 8; fetch_count = 3 after the third handshake.
- Stall: drop if_ready for 3 cycles while if_instr = fc800113, then raise it. Required response: if_instr, if_pc = 4 and if_valid hold unchanged during the stall; the next value is 021101b3; fetch_count does not advance during the stall.
- Redirect: pulse redirect_valid with redirect_pc = 32'h1C while if_ready=1. Required response: one cycle with if_valid = 0, then if_pc = 32'h1C and if_instr = mem[7] = 02117433.
- Out of range: redirect to 32'h80 with ADDR_WIDTH=5. Required response: if_instr = 32'h00000013, if_pc = 32'h80 then 32'h84, and imem data is ignored.
- Misaligned redirect: redirect_pc = 32'h06. Required response: fetch_fault = 1 and if_valid = 0 after the next edge; a later aligned redirect is ignored; asserting rst_n low restores pc = RESET_PC and fetch_fault = 0.
- Simultaneous redirect and handshake, plus async reset: assert redirect_valid while if_valid && if_ready. Required response: fetch_count increments and if_valid falls next cycle. Then assert rst_n low mid-stall between clock edges. Required response: outputs reach their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, instruction memory addressing and the IF/ID
// output register with a valid/ready handshake toward decode. Branch/jump
// redirects from execute flush the output register; a misaligned redirect
// target locks the stage in FAULT until reset.
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter logic [31:0] RESET_PC   = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_data,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [31:0]           if_instr,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_pc_plus4,
    output logic                  fetch_fault,
    output logic [31:0]           fetch_count
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        in_range;
    logic        load;
    logic [31:0] fetched;

    // Memory is addressed from the registered pc only, so redirect_pc never
    // reaches imem_addr combinationally.
    assign imem_addr = pc[ADDR_WIDTH+1:2];

    // Any pc bit above the mapped region means the word is outside memory;
    // such addresses return a NOP instead of aliasing back into the array.
    assign in_range = (pc >> (ADDR_WIDTH + 2)) == '0;
    assign fetched  = in_range ? imem_data : NOP;

    assign load = (state == RUN) && (!if_valid || if_ready);

    // Fetch state machine: pc, IF/ID register, fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_valid    <= 1'b0;
            if_instr    <= NOP;
            if_pc       <= RESET_PC;
            if_pc_plus4 <= RESET_PC + 32'd4;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_valid) begin
                        if_valid <= 1'b0;
                        if (redirect_pc[1:0] == 2'b00) begin
                            pc <= redirect_pc;
                        end else begin
                            state       <= FAULT;
                            fetch_fault <= 1'b1;
                        end
                    end else if (load) begin
                        if_instr    <= fetched;
                        if_pc       <= pc;
                        if_pc_plus4 <= pc + 32'd4;
                        if_valid    <= 1'b1;
                        pc          <= pc + 32'd4;
                    end
                end
                FAULT: begin
                    if_valid    <= 1'b0;
                    fetch_fault <= 1'b1;
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

    // Handshake counter; counts even when a redirect flushes the same cycle,
    // since decode has already taken the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (if_valid && if_ready) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a small combinational
// instruction memory and hand-computed expected values.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [4:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [32];
    int checks = 0;
    int errors = 0;

    instruction_fetch #(
        .ADDR_WIDTH(5),
        .RESET_PC  (32'h00000000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc_plus4   (if_pc_plus4),
        .fetch_fault   (fetch_fault),
        .fetch_count   (fetch_count)
    );

    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 32'(if_valid), 32'd0);
        check({tag, "_instr"}, if_instr, 32'h00000013);
        check({tag, "_pc"}, if_pc, 32'h0);
        check({tag, "_pc4"}, if_pc_plus4, 32'h4);
        check({tag, "_fault"}, 32'(fetch_fault), 32'd0);
        check({tag, "_count"}, fetch_count, 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA5000000 | i;
        mem[0] = 32'h01200093;
        mem[1] = 32'hfc800113;
        mem[2] = 32'h021101b3;
        mem[7] = 32'h02117433;

        rst_n          = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #12;
        check_reset_values("reset");

        // Streaming
        rst_n    = 1'b1;
        if_ready = 1'b1;
        tick();
        check("s0_instr", if_instr, 32'h01200093);
        check("s0_pc", if_pc, 32'h0);
        check("s0_valid", 32'(if_valid), 32'd1);
        check("s0_count", fetch_count, 32'd0);
        check("s0_addr", 32'(imem_addr), 32'd1);
        tick();
        check("s1_instr", if_instr, 32'hfc800113);
        check("s1_pc", if_pc, 32'h4);
        check("s1_count", fetch_count, 32'd1);

        // Stall for three cycles
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_instr", if_instr, 32'hfc800113);
            check("stall_pc", if_pc, 32'h4);
            check("stall_valid", 32'(if_valid), 32'd1);
            check("stall_count", fetch_count, 32'd1);
        end
        if_ready = 1'b1;
        tick();
        check("s2_instr", if_instr, 32'h021101b3);
        check("s2_pc", if_pc, 32'h8);
        check("s2_pc4", if_pc_plus4, 32'hC);
        check("s2_count", fetch_count, 32'd2);
        tick();
        check("s3_instr", if_instr, 32'hA5000003);
        check("s3_pc", if_pc, 32'hC);
        check("s3_count", fetch_count, 32'd3);

        // Redirect to 0x1C together with a handshake
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1C;
        #1;
        check("redir_no_comb_addr", 32'(imem_addr), 32'd4);
        tick();
        check("redir_bubble", 32'(if_valid), 32'd0);
        check("redir_count", fetch_count, 32'd4);
        check("redir_addr", 32'(imem_addr), 32'd7);
        redirect_valid = 1'b0;
        tick();
        check("redir_instr", if_instr, 32'h02117433);
        check("redir_pc", if_pc, 32'h1C);
        check("redir_pc4", if_pc_plus4, 32'h20);
        check("redir_valid", 32'(if_valid), 32'd1);
        check("redir_count2", fetch_count, 32'd4);

        // Out of range region
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        check("oor_bubble", 32'(if_valid), 32'd0);
        check("oor_count", fetch_count, 32'd5);
        redirect_valid = 1'b0;
        tick();
        check("oor0_instr", if_instr, 32'h00000013);
        check("oor0_pc", if_pc, 32'h80);
        check("oor0_pc4", if_pc_plus4, 32'h84);
        check("oor0_valid", 32'(if_valid), 32'd1);
        check("oor_addr_wrap", 32'(imem_addr), 32'd1);
        tick();
        check("oor1_instr", if_instr, 32'h00000013);
        check("oor1_pc", if_pc, 32'h84);
        check("oor1_count", fetch_count, 32'd6);

        // Redirect during a stall, then back-to-back redirects
        if_ready = 1'b0;
        tick();
        check("st2_pc", if_pc, 32'h84);
        check("st2_count", fetch_count, 32'd6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h08;
        tick();
        check("stall_flush_valid", 32'(if_valid), 32'd0);
        check("stall_flush_count", fetch_count, 32'd6);
        redirect_pc = 32'h10;
        tick();
        check("b2b0_valid", 32'(if_valid), 32'd0);
        check("b2b0_addr", 32'(imem_addr), 32'd4);
        redirect_pc = 32'h14;
        tick();
        check("b2b1_valid", 32'(if_valid), 32'd0);
        check("b2b1_addr", 32'(imem_addr), 32'd5);
        redirect_valid = 1'b0;
        tick();
        check("b2b_instr", if_instr, 32'hA5000005);
        check("b2b_pc", if_pc, 32'h14);
        check("b2b_valid", 32'(if_valid), 32'd1);

        // Misaligned redirect with a simultaneous handshake
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h06;
        tick();
        check("mis_fault", 32'(fetch_fault), 32'd1);
        check("mis_valid", 32'(if_valid), 32'd0);
        check("mis_count", fetch_count, 32'd7);
        check("mis_addr", 32'(imem_addr), 32'd6);
        redirect_pc = 32'h1C;
        tick();
        check("fault_ignore_addr", 32'(imem_addr), 32'd6);
        check("fault_ignore_valid", 32'(if_valid), 32'd0);
        check("fault_sticky", 32'(fetch_fault), 32'd1);
        check("fault_pc_hold", if_pc, 32'h14);
        redirect_valid = 1'b0;
        tick();
        check("fault_idle_valid", 32'(if_valid), 32'd0);
        check("fault_idle_count", fetch_count, 32'd7);

        // Asynchronous reset out of FAULT, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_fault");
        #1;
        rst_n = 1'b1;
        tick();
        check("rs0_instr", if_instr, 32'h01200093);
        check("rs0_valid", 32'(if_valid), 32'd1);
        tick();
        check("rs1_instr", if_instr, 32'hfc800113);
        check("rs1_count", fetch_count, 32'd1);

        // Asynchronous reset in the middle of a stall
        if_ready = 1'b0;
        tick();
        check("rs_stall_instr", if_instr, 32'hfc800113);
        check("rs_stall_count", fetch_count, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_stall");
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_instr", if_instr, 32'h01200093);
        check("post_rst_pc", if_pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
